// File: rtl/candy_pkg.sv
// Shared types and defaults for the candy/snack dispense sequencer.
// Default timing constants assume a 12 MHz clk_x1.
package candy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_UNIT_CYC  = 12_000_000;
  localparam int DEF_GAP_CYC   = 1_200_000;
  localparam int DEF_STEP_HALF = 6000;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dispense_seq_ctrl_if.sv
// Host command pins and actuator outputs of the dispense sequencer.
interface dispense_seq_ctrl_if
  import candy_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int AMT_W = 2
);
  localparam int CH_W = ch_w(N_CH);

  logic              req_valid;
  logic [CH_W-1:0]   req_ch;
  logic [AMT_W-1:0]  req_amt;
  logic              step;
  logic              dir;
  logic [N_CH-1:0]   dc_en;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_ch, req_amt,
    input  step, dir, dc_en, busy, done, err
  );

  modport slave (
    input  req_valid, req_ch, req_amt,
    output step, dir, dc_en, busy, done, err
  );

endinterface

// File: rtl/sync_rise_det.sv
// Two-flop synchroniser for an asynchronous level plus a rising-edge detector.
// HIST_RST sets the history flop's reset value.
module sync_rise_det #(
  parameter logic HIST_RST = 1'b1
) (
  input  logic clk_x1,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic sync1, sync2, hist;
  logic [1:0] prime;

  // History holds its reset value until the synchroniser has flushed, so a
  // level already present at reset release is not mistaken for an edge.
  always_ff @(posedge clk_x1 or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= HIST_RST;
      prime <= 2'b00;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prime <= {prime[0], 1'b1};
      if (prime[1]) hist <= sync2;
    end
  end

  assign rise = sync2 & ~hist & prime[1];

endmodule

// File: rtl/dispense_seq_ctrl.sv
// Dispense sequencer: per-unit stepper or DC-motor actuation with inter-unit
// gaps, one-cycle done on completion and err on an out-of-range channel.
module dispense_seq_ctrl
  import candy_pkg::*;
#(
  parameter int              N_CH       = 3,
  parameter int              AMT_W      = 2,
  parameter logic [N_CH-1:0] CH_STEPPER = N_CH'(1),
  parameter int              UNIT_CYC   = DEF_UNIT_CYC,
  parameter int              GAP_CYC    = DEF_GAP_CYC,
  parameter int              STEP_HALF  = DEF_STEP_HALF,
  parameter logic            DIR_CW     = 1'b1
) (
  input logic                clk_x1,
  input logic                rst,
  dispense_seq_ctrl_if.slave bus
);

  localparam int CH_W    = ch_w(N_CH);
  localparam int MAX_CYC = (UNIT_CYC > GAP_CYC) ? UNIT_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int HALF_W  = $clog2(STEP_HALF + 1);

  localparam logic [CNT_W-1:0]  UNIT_LAST = CNT_W'(UNIT_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(STEP_HALF - 1);
  localparam logic [CH_W:0]     CH_LIMIT  = (CH_W + 1)'(N_CH);
  localparam logic [AMT_W:0]    UNIT_ONE  = (AMT_W + 1)'(1);

  if (UNIT_CYC % (2 * STEP_HALF) != 0) begin : g_bad_step_half
    $error("UNIT_CYC must be a multiple of 2*STEP_HALF");
  end

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [AMT_W:0]     units;
  logic [CH_W-1:0]    ch_q;
  logic [HALF_W-1:0]  half_cnt;
  logic               step_q, dir_q, err_q;
  logic               rise, req_ok, run_step;

  sync_rise_det #(.HIST_RST(1'b1)) u_sync (
    .clk_x1   (clk_x1),
    .rst      (rst),
    .async_in (bus.req_valid),
    .rise     (rise)
  );

  assign req_ok = {1'b0, bus.req_ch} < CH_LIMIT;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rise && req_ok) state_n = RUN;
      RUN:     if (cnt == UNIT_LAST) state_n = (units == UNIT_ONE) ? DONE : GAP;
      GAP:     if (cnt == GAP_LAST) state_n = RUN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_x1 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      units    <= '0;
      ch_q     <= '0;
      half_cnt <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= (state == IDLE) && rise && !req_ok;

      if (state_n != state || state == IDLE) cnt <= '0;
      else                                   cnt <= cnt + CNT_W'(1);

      if (state == IDLE && state_n == RUN) begin
        ch_q  <= bus.req_ch;
        units <= {1'b0, bus.req_amt} + UNIT_ONE;
        if (CH_STEPPER[bus.req_ch]) dir_q <= DIR_CW;
      end else if (state == RUN && cnt == UNIT_LAST) begin
        units <= units - UNIT_ONE;
      end

      // Step phase restarts high at the start of every unit.
      if (state_n == RUN && state != RUN) begin
        step_q   <= 1'b1;
        half_cnt <= HALF_LAST;
      end else if (state == RUN) begin
        if (half_cnt == '0) begin
          step_q   <= ~step_q;
          half_cnt <= HALF_LAST;
        end else begin
          half_cnt <= half_cnt - HALF_W'(1);
        end
      end
    end
  end

  assign run_step  = (state == RUN) && CH_STEPPER[ch_q];
  assign bus.step  = run_step && step_q;
  assign bus.dir   = dir_q;
  assign bus.dc_en = (state == RUN && !CH_STEPPER[ch_q]) ? (N_CH'(1) << ch_q) : '0;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.err   = err_q;

endmodule

// File: tb/tb_dispense_seq_ctrl.sv
// Directed bench for dispense_seq_ctrl with short unit/gap timing
// (UNIT_CYC=8, GAP_CYC=4, STEP_HALF=2, channel 0 stepper).
`timescale 1ns/1ps
module tb_dispense_seq_ctrl;

  logic clk_x1 = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_x1 = ~clk_x1;

  dispense_seq_ctrl_if #(.N_CH(3), .AMT_W(2)) bus ();

  dispense_seq_ctrl #(
    .N_CH       (3),
    .AMT_W      (2),
    .CH_STEPPER (3'b001),
    .UNIT_CYC   (8),
    .GAP_CYC    (4),
    .STEP_HALF  (2),
    .DIR_CW     (1'b1)
  ) dut (
    .clk_x1 (clk_x1),
    .rst    (rst),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_x1);
    #1;
  endtask

  // Issue one request and watch 40 cycles from the first RUN cycle.
  task automatic do_request(input string tag, input int ch, input int amt, input bit repulse,
                            input int exp_busy, input int exp_dc, input int exp_pulses,
                            input int exp_done_at, input logic exp_dir);
    int       units, total, p;
    int       n_busy, n_dc, n_pulse, done_at, n_bad;
    logic     e_step, e_busy, e_done, prev_step;
    logic [2:0] e_dc;
    bit       stepper;
    units     = amt + 1;
    total     = units * 12 - 4;
    stepper   = (ch == 0);
    n_busy    = 0;
    n_dc      = 0;
    n_pulse   = 0;
    n_bad     = 0;
    done_at   = -1;
    prev_step = 1'b0;

    bus.req_ch  = 2'(ch);
    bus.req_amt = 2'(amt);
    repeat (3) tick();
    bus.req_valid = 1'b1;
    tick();
    tick();
    check({tag, "_busy_pre"}, 32'(bus.busy), 32'd0);
    tick();
    check({tag, "_busy_first"}, 32'(bus.busy), 32'd1);

    for (int k = 0; k < 40; k++) begin
      e_step = 1'b0;
      e_dc   = 3'b000;
      e_busy = 1'b0;
      e_done = 1'b0;
      if (k < total) begin
        p      = k % 12;
        e_busy = 1'b1;
        if (p < 8) begin
          if (stepper) e_step = ((p % 4) < 2);
          else         e_dc   = 3'(1 << ch);
        end
      end else if (k == total) begin
        e_busy = 1'b1;
        e_done = 1'b1;
      end
      if ({bus.step, bus.dc_en, bus.busy, bus.done, bus.err} !==
          {e_step, e_dc, e_busy, e_done, 1'b0}) n_bad++;
      if (bus.busy) n_busy++;
      if (bus.dc_en != 3'b000) n_dc++;
      if (bus.step && !prev_step) n_pulse++;
      prev_step = bus.step;
      if (bus.done && done_at < 0) done_at = k;

      if (repulse) begin
        if (k == 1) bus.req_valid = 1'b0;
        if (k == 4) bus.req_valid = 1'b1;
        if (k == 8) bus.req_valid = 1'b0;
      end else if (k == 2) begin
        bus.req_valid = 1'b0;
      end
      tick();
    end

    check({tag, "_pattern_bad"}, 32'(n_bad), 32'd0);
    check({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_busy));
    check({tag, "_dc_cycles"}, 32'(n_dc), 32'(exp_dc));
    check({tag, "_step_pulses"}, 32'(n_pulse), 32'(exp_pulses));
    check({tag, "_done_at"}, 32'(done_at), 32'(exp_done_at));
    check({tag, "_dir"}, 32'(bus.dir), 32'(exp_dir));
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic act;
    int   n_done;

    // 1: flag held high through reset release must not start a request
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_ch    = 2'd0;
    bus.req_amt   = 2'd0;
    repeat (2) tick();
    check("rst_step", 32'(bus.step), 32'd0);
    check("rst_dir", 32'(bus.dir), 32'd0);
    check("rst_dc_en", 32'(bus.dc_en), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 12; i++) begin
      act = act | bus.busy | bus.step | bus.err | (bus.dc_en != 3'b000);
      tick();
    end
    check("t1_no_act", 32'(act), 32'd0);
    bus.req_valid = 1'b0;
    repeat (3) tick();

    // 2: DC channel 1, one unit
    do_request("t2", 1, 0, 1'b0, 9, 8, 0, 8, 1'b0);

    // 3: stepper channel 0, three units
    do_request("t3", 0, 2, 1'b0, 33, 0, 6, 32, 1'b1);

    // 4: out-of-range channel
    bus.req_ch  = 2'd3;
    bus.req_amt = 2'd1;
    repeat (3) tick();
    bus.req_valid = 1'b1;
    tick();
    tick();
    check("t4_err_pre", 32'(bus.err), 32'd0);
    tick();
    check("t4_err_pulse", 32'(bus.err), 32'd1);
    check("t4_busy", 32'(bus.busy), 32'd0);
    tick();
    check("t4_err_clear", 32'(bus.err), 32'd0);
    act = 1'b0;
    for (int i = 0; i < 10; i++) begin
      act = act | bus.busy | bus.step | bus.err | (bus.dc_en != 3'b000);
      if (i == 1) bus.req_valid = 1'b0;
      tick();
    end
    check("t4_no_act", 32'(act), 32'd0);
    repeat (3) tick();

    // 5: re-pulse during RUN is ignored; next request accepted
    do_request("t5", 2, 1, 1'b1, 21, 16, 0, 20, 1'b1);
    do_request("t5b", 1, 0, 1'b0, 9, 8, 0, 8, 1'b1);

    // 6: reset on the 5th RUN cycle of a stepper request
    bus.req_ch  = 2'd0;
    bus.req_amt = 2'd1;
    repeat (3) tick();
    bus.req_valid = 1'b1;
    repeat (3) tick();
    repeat (4) tick();
    check("t6_step_before", 32'(bus.step), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_step_rst", 32'(bus.step), 32'd0);
    check("t6_busy_rst", 32'(bus.busy), 32'd0);
    check("t6_dc_rst", 32'(bus.dc_en), 32'd0);
    check("t6_dir_rst", 32'(bus.dir), 32'd0);
    tick();
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    n_done = 0;
    act    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) n_done++;
      act = act | bus.busy | bus.step;
      tick();
    end
    check("t6_no_done", 32'(n_done), 32'd0);
    check("t6_no_act", 32'(act), 32'd0);
    do_request("t6b", 0, 0, 1'b0, 9, 0, 2, 8, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
